freq_meas_ctrl: RTL

Measurement-window sequencer for the frequency counter datapath, running on the PLL-derived system clock. It clears the pulse counter, opens a programmable gate window, waits for the enable synchroniser pipeline to drain, then captures the count. The result is handed to the sample/memory store stage over a valid/ready handshake. Supports single-shot and continuous measurement, abort, and counter-wrap (overflow) detection.

---
 rtl/freq_meas_ctrl_if.sv | 29 ++
 rtl/freq_meas_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/freq_meas_ctrl_if.sv
// Bundle of the measurement-sequencer signals: request/config inputs, counter
// control outputs and the result valid/ready handshake toward the store stage.
interface freq_meas_ctrl_if #(
  parameter int GATE_W = 16,
  parameter int CNT_W  = 10
);
  logic              start;
  logic              cont;
  logic              abort;
  logic [GATE_W-1:0] gate_len;
  logic [CNT_W-1:0]  cnt_in;
  logic              cnt_clr;
  logic              meas_en;
  logic [CNT_W-1:0]  res_data;
  logic              res_ovf;
  logic              res_valid;
  logic              res_ready;
  logic              busy;

  modport master (
    output start, cont, abort, gate_len, cnt_in, res_ready,
    input  cnt_clr, meas_en, res_data, res_ovf, res_valid, busy
  );

  modport slave (
    input  start, cont, abort, gate_len, cnt_in, res_ready,
    output cnt_clr, meas_en, res_data, res_ovf, res_valid, busy
  );
endinterface

// File: rtl/freq_meas_ctrl.sv
// Measurement-window sequencer: clear counter, open gate for len_q cycles,
// drain the enable pipeline, capture the count and hand it off via valid/ready.
module freq_meas_ctrl #(
  parameter int GATE_W = 16,
  parameter int CNT_W  = 10,
  parameter int SETTLE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  freq_meas_ctrl_if.slave      bus
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]     S_LAST = SW'(SETTLE - 1);
  localparam logic [GATE_W-1:0] G_ONE  = GATE_W'(1);
  localparam logic [SW-1:0]     S_ONE  = SW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_GATE    = 3'd2,
    S_SETTLE  = 3'd3,
    S_CAPTURE = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [GATE_W-1:0] len_q, len_d;
  logic [GATE_W-1:0] gcnt_q, gcnt_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic [CNT_W-1:0]  prev_q, prev_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  res_data_q, res_data_d;
  logic              res_ovf_q, res_ovf_d;
  logic              res_valid_q, res_valid_d;
  logic              cnt_clr_q, cnt_clr_d;
  logic              meas_en_q, meas_en_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    gcnt_d     = gcnt_q;
    scnt_d     = scnt_q;
    prev_d     = prev_q;
    ovf_d      = ovf_q;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        len_d   = (bus.gate_len == '0) ? G_ONE : bus.gate_len;
        gcnt_d  = '0;
        scnt_d  = '0;
        prev_d  = '0;
        ovf_d   = 1'b0;
        state_d = S_GATE;
      end
      S_GATE: begin
        if (gcnt_q == len_q - G_ONE) begin
          scnt_d  = '0;
          state_d = S_SETTLE;
        end else begin
          gcnt_d = gcnt_q + G_ONE;
        end
      end
      S_SETTLE: begin
        if (scnt_q == S_LAST) state_d = S_CAPTURE;
        else                  scnt_d  = scnt_q + S_ONE;
      end
      S_CAPTURE: begin
        res_data_d = bus.cnt_in;
        res_ovf_d  = ovf_q;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (bus.res_ready) state_d = bus.cont ? S_CLEAR : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A drop in the live count while counting means the counter wrapped.
    if (state_q == S_GATE || state_q == S_SETTLE) begin
      if (bus.cnt_in < prev_q) ovf_d = 1'b1;
      prev_d = bus.cnt_in;
    end

    if (state_q != S_IDLE && bus.abort) state_d = S_IDLE;

    // Outputs decoded from the next state so they leave straight from flops.
    cnt_clr_d   = (state_d == S_CLEAR);
    meas_en_d   = (state_d == S_GATE);
    res_valid_d = (state_d == S_HOLD);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      gcnt_q      <= '0;
      scnt_q      <= '0;
      prev_q      <= '0;
      ovf_q       <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      cnt_clr_q   <= 1'b0;
      meas_en_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      gcnt_q      <= gcnt_d;
      scnt_q      <= scnt_d;
      prev_q      <= prev_d;
      ovf_q       <= ovf_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
      cnt_clr_q   <= cnt_clr_d;
      meas_en_q   <= meas_en_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cnt_clr   = cnt_clr_q;
  assign bus.meas_en   = meas_en_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = busy_q;

endmodule
